// File: rtl/ma_pkg.sv
// Shared types for the moving-average channel scheduler.
// Channel indices, sample width and scheduler FSM states.
package ma_pkg;

    localparam int NUM_CH   = 3;
    localparam int SAMPLE_W = 2;
    localparam int CH_W     = 2;
    localparam int FILL_W   = 4;

    typedef logic [CH_W-1:0]     ch_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        SEND  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    // Next channel index, wrapping after the last channel.
    function automatic ch_t ch_next(input ch_t c);
        return (c == ch_t'(NUM_CH - 1)) ? '0 : c + 1'b1;
    endfunction

endpackage

// File: rtl/ma_rr_arbiter.sv
// Combinational round-robin arbiter for the channel scheduler.
// Search starts at the channel after last and wraps once.
module ma_rr_arbiter
    import ma_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_t               last,
    output logic [NUM_CH-1:0] grant
);

    ch_t c;

    // Walk channels from last+1; the first requester wins.
    always_comb begin
        grant = '0;
        c     = ch_next(last);
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[c] && (grant == '0)) begin
                grant[c] = 1'b1;
            end
            c = ch_next(c);
        end
    end

endmodule

// File: rtl/ma_chan_sched.sv
// Three-channel scheduler feeding one shared moving-average datapath.
// Optional window flush is built when MA_SCHED_FLUSH_EN is defined.
module ma_chan_sched
    import ma_pkg::*;
#(
    parameter int WINDOW_SIZE = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   req_data,
    output logic [NUM_CH-1:0]            req_ready,
    output logic                         dp_valid,
    output ch_t                          dp_chan,
    output sample_t                      dp_data,
    input  logic                         dp_ready,
    output logic [NUM_CH-1:0]            win_full,
    input  logic                         flush_req,
    output logic                         flush_busy
);

    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WINDOW_SIZE);

    state_e              state;
    state_e              state_nx;
    ch_t                 last_grant;
    logic [NUM_CH-1:0]   req_snap;
    logic [NUM_CH-1:0]   grant;
    ch_t                 gnt_ch;
    sample_t             gnt_data;
    ch_t                 cap_chan;
    sample_t             cap_data;
    logic [FILL_W-1:0]   fill [NUM_CH];
    logic                flush_pend;
    logic                fill_clr;
    logic                any_req;

    assign any_req = |req_valid;

    ma_rr_arbiter u_arb (
        .req   (req_snap),
        .last  (last_grant),
        .grant (grant)
    );

    // Convert the one-hot grant to an index and pick its sample.
    always_comb begin
        gnt_ch   = '0;
        gnt_data = '0;
        unique case (1'b1)
            grant[0]: gnt_ch = 2'd0;
            grant[1]: gnt_ch = 2'd1;
            grant[2]: gnt_ch = 2'd2;
            default:  gnt_ch = 2'd0;
        endcase
        gnt_data = req_data[gnt_ch*SAMPLE_W +: SAMPLE_W];
    end

`ifdef MA_SCHED_FLUSH_EN
    ch_t               flush_ch;
    logic [FILL_W-1:0] flush_cnt;
    logic              flush_last;

    assign flush_last = (flush_ch == ch_t'(NUM_CH - 1)) &&
                        (flush_cnt == FILL_W'(WINDOW_SIZE - 1));
    assign fill_clr   = (state == FLUSH) && dp_ready && flush_last;

    // Latch one flush request; drop it when the flush begins.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            flush_pend <= 1'b0;
        end else if ((state != FLUSH) && (state_nx == FLUSH)) begin
            flush_pend <= 1'b0;
        end else if (flush_req && (state != FLUSH)) begin
            flush_pend <= 1'b1;
        end
    end

    // Step through WINDOW_SIZE zero samples per channel.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            flush_ch  <= '0;
            flush_cnt <= '0;
        end else if ((state == FLUSH) && dp_ready) begin
            if (flush_cnt == FILL_W'(WINDOW_SIZE - 1)) begin
                flush_cnt <= '0;
                flush_ch  <= flush_last ? '0 : ch_next(flush_ch);
            end else begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_flush_req;

    assign unused_flush_req = flush_req;
    assign flush_pend       = 1'b0;
    assign fill_clr         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (flush_pend) begin
                    state_nx = FLUSH;
                end else if (any_req) begin
                    state_nx = ARB;
                end
            end
            ARB: begin
                state_nx = (|grant) ? SEND : IDLE;
            end
            SEND: begin
                if (dp_ready) begin
                    if (flush_pend) begin
                        state_nx = FLUSH;
                    end else if (any_req) begin
                        state_nx = ARB;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            FLUSH: begin
`ifdef MA_SCHED_FLUSH_EN
                if (dp_ready && flush_last) begin
                    state_nx = IDLE;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state and captured sample.
    always_comb begin
        req_ready  = '0;
        dp_valid   = 1'b0;
        dp_chan    = cap_chan;
        dp_data    = cap_data;
        flush_busy = 1'b0;
        unique case (state)
            IDLE:  ;
            ARB:   req_ready = grant;
            SEND:  dp_valid = 1'b1;
            FLUSH: begin
`ifdef MA_SCHED_FLUSH_EN
                dp_valid   = 1'b1;
                dp_chan    = flush_ch;
                dp_data    = '0;
                flush_busy = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Snapshot requests outside ARB; capture the granted sample in ARB.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_grant <= ch_t'(NUM_CH - 1);
            req_snap   <= '0;
            cap_chan   <= '0;
            cap_data   <= '0;
        end else begin
            if (state != ARB) begin
                req_snap <= req_valid;
            end
            if ((state == ARB) && (|grant)) begin
                last_grant <= gnt_ch;
                cap_chan   <= gnt_ch;
                cap_data   <= gnt_data;
            end
        end
    end

    // Per-channel fill counters, saturating at the window size.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fill[i] <= '0;
            end
        end else if (fill_clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                fill[i] <= '0;
            end
        end else if ((state == SEND) && dp_ready) begin
            if (fill[cap_chan] != FILL_MAX) begin
                fill[cap_chan] <= fill[cap_chan] + 1'b1;
            end
        end
    end

    // Window-full flags.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            win_full[i] = (fill[i] == FILL_MAX);
        end
    end

endmodule

// File: doc/ma_chan_sched.md
MA_CHAN_SCHED -- requirements
Module: ma_chan_sched

Interface
REQ-001 Parameter WINDOW_SIZE, default 2, samples per channel window; legal range 2..8.
REQ-002 Parameter NUM_CH, fixed at 3; channels 0=x, 1=y, 2=t.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high; clock is clk.
REQ-005 req_valid  input  3  per-channel sample-valid, one bit per channel.
REQ-006 req_data  input  6  per-channel 2-bit samples; channel c occupies bits [2c+1:2c].
REQ-007 req_ready  output  3  per-channel accept; at most one bit high per cycle.
REQ-008 dp_valid  output  1  sample presented to the shared moving-average datapath.
REQ-009 dp_chan  output  2  channel index of the presented sample.
REQ-010 dp_data  output  2  presented sample value.
REQ-011 dp_ready  input  1  datapath accepts the presented sample.
REQ-012 win_full  output  3  per-channel flag: WINDOW_SIZE samples delivered since reset or flush.
REQ-013 flush_req  input  1  single-cycle pulse requesting a window flush.
REQ-014 flush_busy  output  1  flush sequence in progress.

Function
REQ-015 FSM states IDLE, ARB, SEND, FLUSH; transitions only on clk.
REQ-016 IDLE -> ARB when any req_valid bit is high and no flush is pending; otherwise stays in IDLE.
REQ-017 ARB: round-robin grant, searching from last_grant+1 mod 3; grant one valid channel; pulse its req_ready for exactly one cycle; capture its sample; go to SEND.
REQ-018 last_grant updates only on a grant; its reset value is 2, so channel 0 wins first.
REQ-019 SEND: dp_valid=1; dp_chan/dp_data hold constant until dp_valid&dp_ready.
REQ-020 SEND exit on dp_ready: go to FLUSH if a flush is pending; else go to ARB if any req_valid; else go to IDLE.
REQ-021 Latency: a sample accepted by req_ready in cycle N appears on dp_valid in cycle N+1; zero wait states when dp_ready is held at 1.
REQ-022 If req_valid of the granted channel drops during ARB, the capture still completes; requesters must hold data while valid.
REQ-023 Fill counter per channel increments on each dp handshake for that channel and saturates at WINDOW_SIZE; win_full[c] = (count[c] == WINDOW_SIZE).
REQ-024 Widths: fill counters are 4 bits; no counter wraps.
REQ-025 A flush_req arriving in any state is latched as pending; a second pulse while pending or busy is ignored.
REQ-026 req_ready stays 0 in FLUSH.

Reset
REQ-027 While rst_n=1, immediately and independent of clk: state=IDLE, req_ready=0, dp_valid=0, dp_chan=0, dp_data=0, win_full=0, flush_busy=0, flush pending cleared, last_grant=2, fill counters cleared.
REQ-028 Reset mid-SEND drops the in-flight sample; no replay after reset release.

Configuration
REQ-029 With macro MA_SCHED_FLUSH_EN defined: FLUSH issues WINDOW_SIZE zero samples per channel in order ch0, ch1, ch2, each via the dp handshake; flush_busy=1 throughout; all fill counters clear on the final handshake; then go to IDLE.
REQ-030 Without MA_SCHED_FLUSH_EN: flush_req is ignored, flush_busy is tied 0, the FLUSH state is unreachable, and no pending flush is ever latched.

Structure
REQ-031 Shared package ma_pkg holds NUM_CH, SAMPLE_W=2, the FSM state enum, and the channel-index typedef.
REQ-032 Round-robin grant logic lives in sub-module ma_rr_arbiter: request vector and last_grant in, one-hot grant out, combinational.

Verification
REQ-033 Reset, then req_valid=3'b111 with dp_ready=1 -> grant order 0,1,2,0; dp_chan sequence 0,1,2,0 on consecutive handshakes.
REQ-034 ch1 valid with data 2'b10, dp_ready=0 for 5 cycles -> dp_valid=1, dp_chan=1, dp_data=2 stable for all 5 cycles; req_ready[1] pulses once only.
REQ-035 Three ch2 handshakes with WINDOW_SIZE=2 -> win_full[2] rises after the 2nd handshake and stays 1 after the 3rd.
REQ-036 MA_SCHED_FLUSH_EN defined, flush_req during SEND -> the current sample completes first; then 6 zero samples on ch 0,0,1,1,2,2; win_full=0; flush_busy falls.
REQ-037 rst_n asserted mid-SEND, between clock edges -> dp_valid=0 before the next edge; after release, ch0 wins first.
